// File: rtl/imem_sync.sv
// Clocked instruction memory with a run-time loader, programmable wait states
// and a valid/ready fetch handshake. Single outstanding request.
//
// state  | meaning
// IDLE   | ready for a fetch (unless the loader is writing this cycle)
// WAIT   | request accepted, counting down wait states
// RESP   | response word valid, held until the consumer takes it
module imem_sync #(
    parameter int unsigned ADDR_BITS     = 4,
    parameter int unsigned LATENCY       = 0,
    parameter logic [31:0] DEFAULT_INSTR = 32'hEAFF_FFFE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [31:0]          req_addr,
    output logic                 req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 oor_q, oor_d;
    logic                 mis_q, mis_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [ADDR_BITS-1:0] req_idx;
    logic                 req_oor;
    logic                 req_mis;
    logic                 capture;
    logic [ADDR_BITS-1:0] cap_idx;
    logic                 cap_oor;
    logic                 cap_mis;

    // Contents survive reset; the initializer only sets power-up contents.
    logic [31:0] mem_q [0:DEPTH-1] = '{default: DEFAULT_INSTR};

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign req_idx   = req_addr[ADDR_BITS+1:2];
    assign req_oor   = |req_addr[31:ADDR_BITS+2];
    assign req_mis   = |req_addr[1:0];
    assign req_ready = (state_q == S_IDLE) && !load_en;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        oor_d       = oor_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        capture     = 1'b0;
        cap_idx     = idx_q;
        cap_oor     = oor_q;
        cap_mis     = mis_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    idx_d = req_idx;
                    oor_d = req_oor;
                    mis_d = req_mis;
                    if (LATENCY != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end else begin
                        // Zero wait states: capture straight from the request.
                        state_d = S_RESP;
                        capture = 1'b1;
                        cap_idx = req_idx;
                        cap_oor = req_oor;
                        cap_mis = req_mis;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load hitting the captured word in the same cycle wins (write-first).
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cap_oor | cap_mis;
            if (cap_oor) begin
                rsp_data_d = DEFAULT_INSTR;
            end else if (load_en && (load_addr == cap_idx)) begin
                rsp_data_d = load_data;
            end else begin
                rsp_data_d = mem_q[cap_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            oor_q       <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DEFAULT_INSTR;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            oor_q       <= oor_d;
            mis_q       <= mis_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: three instances (0, 2 and 3 wait states) share the loader,
// address and response-ready inputs; each has its own request strobe.
module tb_imem_sync;

    localparam logic [31:0] DEF = 32'hEAFF_FFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_v [3];
    logic [31:0] req_addr = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = 4'h0;
    logic [31:0] load_data = 32'h0;

    logic        req_ready_w [3];
    logic        rsp_valid_w [3];
    logic [31:0] rsp_data_w  [3];
    logic        rsp_err_w   [3];
    logic        busy_w      [3];

    int cmp_n = 0;
    int err_n = 0;

    always #5 clk = ~clk;

    imem_sync #(.ADDR_BITS(4), .LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_addr(req_addr),
        .req_ready(req_ready_w[0]), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_w[0]), .rsp_err(rsp_err_w[0]), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_w[0]));

    imem_sync #(.ADDR_BITS(4), .LATENCY(2)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_addr(req_addr),
        .req_ready(req_ready_w[1]), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_w[1]), .rsp_err(rsp_err_w[1]), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_w[1]));

    imem_sync #(.ADDR_BITS(4), .LATENCY(3)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_addr(req_addr),
        .req_ready(req_ready_w[2]), .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_w[2]), .rsp_err(rsp_err_w[2]), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request accepted at edge number a yields its response in
    // the cycle after edge a+lat; the word is memory as it stands after that edge.
    int          lat [3] = '{0, 2, 3};
    logic [31:0] mem [16];
    bit          m_valid [3];
    bit          m_pend  [3];
    logic [31:0] m_data  [3];
    bit          m_err   [3];
    int          m_acc   [3];
    logic [31:0] m_addr  [3];
    bit          armed = 0;
    int          cyc = 0;

    function automatic logic [31:0] word_for(input logic [31:0] a);
        if (a >= 32'h40) return DEF;
        return mem[a / 4];
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DEF;
        for (int k = 0; k < 3; k++) begin
            req_valid_v[k] = 1'b0;
            m_valid[k] = 0; m_pend[k] = 0; m_data[k] = DEF; m_err[k] = 0;
            m_acc[k] = 0; m_addr[k] = 32'h0;
        end
    end

    always @(posedge clk) begin
        bit do_cap [3];
        if (load_en) mem[load_addr] = load_data;
        for (int k = 0; k < 3; k++) begin
            do_cap[k] = 0;
            if (reset) begin
                m_valid[k] = 0; m_pend[k] = 0; m_data[k] = DEF; m_err[k] = 0;
            end else if (m_valid[k]) begin
                if (rsp_ready) m_valid[k] = 0;
            end else if (m_pend[k]) begin
                if (cyc == m_acc[k] + lat[k]) do_cap[k] = 1;
            end else if (req_valid_v[k] && !load_en) begin
                m_acc[k]  = cyc;
                m_addr[k] = req_addr;
                m_pend[k] = 1;
                if (lat[k] == 0) do_cap[k] = 1;
            end
            if (do_cap[k]) begin
                m_pend[k]  = 0;
                m_valid[k] = 1;
                m_data[k]  = word_for(m_addr[k]);
                m_err[k]   = (m_addr[k] >= 32'h40) || (m_addr[k] % 4 != 0);
            end
        end
        if (reset) armed = 1;
        cyc++;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d rsp_valid", k), 32'(rsp_valid_w[k]), 32'(m_valid[k]));
                chk($sformatf("d%0d rsp_data", k), rsp_data_w[k], m_data[k]);
                chk($sformatf("d%0d rsp_err", k), 32'(rsp_err_w[k]), 32'(m_err[k]));
                chk($sformatf("d%0d busy", k), 32'(busy_w[k]), 32'(m_pend[k] || m_valid[k]));
                chk($sformatf("d%0d req_ready", k), 32'(req_ready_w[k]),
                    32'(!m_pend[k] && !m_valid[k] && !load_en));
            end
        end
    end

    // Entered and left at #1 after a rising edge.
    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic fetch(input int k, input logic [31:0] addr, input int hold,
                         input int ld_cyc, input logic [3:0] ld_a, input logic [31:0] ld_d,
                         output logic [31:0] data, output logic err, output int lat_seen);
        bit got = 0;
        req_addr = addr;
        req_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[k] = 1'b0;
        lat_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            if (ld_cyc == i) begin
                load_en = 1'b1; load_addr = ld_a; load_data = ld_d;
            end else begin
                load_en = 1'b0;
            end
            @(negedge clk);
            lat_seen = i;
            if (rsp_valid_w[k]) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        if (!got) begin
            chk($sformatf("d%0d response timeout", k), 32'd0, 32'd1);
            data = 32'hx; err = 1'bx;
            @(posedge clk); #1;
            return;
        end
        data = rsp_data_w[k];
        err  = rsp_err_w[k];
        for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("d%0d held rsp_valid", k), 32'(rsp_valid_w[k]), 32'd1);
            chk($sformatf("d%0d held rsp_data", k), rsp_data_w[k], data);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        bit          seen;

        for (int k = 0; k < 3; k++) req_valid_v[k] = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
        chk("reset rsp_data", rsp_data_w[0], 32'hEAFF_FFFE);
        chk("reset busy", 32'(busy_w[2]), 32'd0);
        chk("reset req_ready", 32'(req_ready_w[1]), 32'd1);
        @(posedge clk); #1;

        fetch(0, 32'h00, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("power-up word", d, 32'hEAFF_FFFE);
        chk("power-up err", 32'(e), 32'd0);
        chk("lat0 latency", 32'(l), 32'd1);

        load_word(4'd0, 32'hE202_2000);
        load_word(4'd1, 32'hE382_3000);
        load_word(4'd2, 32'hE383_4005);
        load_word(4'd3, 32'hE3A0_5062);
        fetch(0, 32'h0C, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("loaded word 3", d, 32'hE3A0_5062);
        chk("loaded err", 32'(e), 32'd0);

        fetch(2, 32'h04, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("lat3 latency", 32'(l), 32'd4);
        chk("lat3 word 1", d, 32'hE382_3000);

        fetch(0, 32'h08, 5, 0, 4'h0, 32'h0, d, e, l);
        chk("backpressure word", d, 32'hE383_4005);

        // Request held high across a stalled response.
        req_addr = 32'h04;
        req_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("held req idle after handshake", 32'(busy_w[0]), 32'd0);
        chk("held req ready after handshake", 32'(req_ready_w[0]), 32'd1);
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("held req re-accepted", 32'(rsp_valid_w[0]), 32'd1);
        chk("held req data", rsp_data_w[0], 32'hE382_3000);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        fetch(0, 32'h40, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("out-of-range word", d, 32'hEAFF_FFFE);
        chk("out-of-range err", 32'(e), 32'd1);
        fetch(0, 32'h0E, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("misaligned word", d, 32'hE3A0_5062);
        chk("misaligned err", 32'(e), 32'd1);

        req_addr = 32'h24;
        req_valid_v[0] = 1'b1;
        load_en = 1'b1; load_addr = 4'd9; load_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("load blocks req_ready", 32'(req_ready_w[0]), 32'd0);
        @(posedge clk); #1;
        load_en = 1'b0;
        req_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("load blocks accept", 32'(busy_w[0]), 32'd0);
        @(posedge clk); #1;
        fetch(0, 32'h24, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("word after collision", d, 32'h0BAD_F00D);

        fetch(1, 32'h08, 0, 1, 4'd2, 32'h1AFF_FFFC, d, e, l);
        chk("load during wait", d, 32'h1AFF_FFFC);
        chk("lat2 latency", 32'(l), 32'd3);
        fetch(1, 32'h08, 0, 2, 4'd2, 32'h1234_5678, d, e, l);
        chk("write-first at capture", d, 32'h1234_5678);

        req_addr = 32'h0C;
        req_valid_v[2] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_w[2] || busy_w[2]) seen = 1;
        end
        chk("reset aborts request", 32'(seen), 32'd0);
        @(posedge clk); #1;
        fetch(0, 32'h24, 0, 0, 4'h0, 32'h0, d, e, l);
        chk("memory kept over reset", d, 32'h0BAD_F00D);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
